// File: rtl/clk_div_bank_pkg.sv
// rtl/clk_div_bank_pkg.sv - shared constants and helpers for the clock divider bank
//
// Purpose: default widths/reset values, the 50 MHz -> 1 Hz preset, the
// channel run-state encoding and divisor helper functions.
// Ports: none (package).
package clk_div_bank_pkg;

  localparam int DEF_W            = 26;
  localparam int DEF_RESET_PERIOD = 49_999_999;
  localparam int DEF_RESET_HIGH   = 25_000_000;

  // 50 MHz in, 1 Hz out, 50 % duty
  localparam int PRESET_1HZ_PERIOD = 49_999_999;
  localparam int PRESET_1HZ_HIGH   = 25_000_000;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_t;

  // Period value P for a target output frequency (period is P+1 cycles).
  function automatic int unsigned div_period(input int unsigned f_in, input int unsigned f_out);
    return f_in / f_out - 1;
  endfunction

  // High time for 50 % duty at period value P.
  function automatic int unsigned div_high(input int unsigned period);
    return (period + 1) / 2;
  endfunction

endpackage

// File: rtl/clk_div_bank_channel.sv
// rtl/clk_div_bank_channel.sv - one divider channel with double-buffered divisors
//
// Purpose: counts 0..period_r, emits a registered divided waveform and a
// period-start tick; new divisors are held in a shadow until a boundary.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   en              run enable
//   wr              write strobe for this channel
//   wr_period       period value P (period is P+1 cycles)
//   wr_high         high time H in cycles
//   clk_out         divided waveform (registered)
//   tick            one-cycle pulse on the first cycle of each period
//   pending         shadow holds a configuration not yet applied
module clk_div_channel
  import clk_div_bank_pkg::*;
#(
  parameter int W            = DEF_W,
  parameter int RESET_PERIOD = DEF_RESET_PERIOD,
  parameter int RESET_HIGH   = DEF_RESET_HIGH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         wr,
  input  logic [W-1:0] wr_period,
  input  logic [W-1:0] wr_high,
  output logic         clk_out,
  output logic         tick,
  output logic         pending
);

  localparam logic [W-1:0] RST_P = W'(RESET_PERIOD);
  localparam logic [W-1:0] RST_H = W'(RESET_HIGH);

  ch_state_t    state, state_nxt;
  logic [W-1:0] period_r, high_r, pend_p, pend_h, cnt;
  logic [W-1:0] period_nxt, high_nxt, cnt_nxt;
  logic         pend_v, pend_v_nxt;
  logic         clk_out_nxt, tick_nxt, boundary;

  always_comb begin
    period_nxt  = period_r;
    high_nxt    = high_r;
    pend_v_nxt  = pend_v;
    cnt_nxt     = '0;
    state_nxt   = state;
    clk_out_nxt = 1'b0;
    tick_nxt    = 1'b0;

    // Divisors may only change while disabled, on start, or at the wrap,
    // so a running period is never cut short or stretched.
    boundary = !en || (state == CH_IDLE) || (cnt == period_r);

    if (boundary) begin
      if (wr) begin
        // write coinciding with a boundary bypasses the shadow
        period_nxt = wr_period;
        high_nxt   = wr_high;
        pend_v_nxt = 1'b0;
      end else if (pend_v) begin
        period_nxt = pend_p;
        high_nxt   = pend_h;
        pend_v_nxt = 1'b0;
      end
    end else if (wr) begin
      pend_v_nxt = 1'b1;
    end

    if (!en) begin
      state_nxt = CH_IDLE;
    end else begin
      state_nxt = CH_RUN;
      // enabled boundary is either the start or the wrap: both restart at 0
      cnt_nxt     = boundary ? '0 : cnt + 1'b1;
      tick_nxt    = boundary;
      clk_out_nxt = (cnt_nxt < high_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CH_IDLE;
      period_r <= RST_P;
      high_r   <= RST_H;
      pend_p   <= '0;
      pend_h   <= '0;
      pend_v   <= 1'b0;
      cnt      <= '0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      state    <= state_nxt;
      period_r <= period_nxt;
      high_r   <= high_nxt;
      pend_v   <= pend_v_nxt;
      cnt      <= cnt_nxt;
      clk_out  <= clk_out_nxt;
      tick     <= tick_nxt;
      if (wr) begin
        pend_p <= wr_period;
        pend_h <= wr_high;
      end
    end
  end

  assign pending = pend_v;

endmodule

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - multi-channel programmable clock-enable divider bank
//
// Purpose: CHANNELS independent dividers sharing one configuration write port.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   en              per-channel run enable
//   wr_en           configuration write strobe
//   wr_ch           channel addressed by the write (>= CHANNELS is ignored)
//   wr_period       period value P (period is P+1 cycles)
//   wr_high         high time H in cycles
//   clk_out         per-channel divided waveform (registered)
//   tick            per-channel period-start pulse (registered)
//   pending         per-channel shadow-valid flag
module clk_div_bank
  import clk_div_bank_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int CH_W         = 2,
  parameter int W            = DEF_W,
  parameter int RESET_PERIOD = DEF_RESET_PERIOD,
  parameter int RESET_HIGH   = DEF_RESET_HIGH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [W-1:0]        wr_period,
  input  logic [W-1:0]        wr_high,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic wr_sel;

    // out-of-range addresses never equal any generated index
    assign wr_sel = wr_en && (wr_ch == CH_W'(i));

    clk_div_channel #(
      .W           (W),
      .RESET_PERIOD(RESET_PERIOD),
      .RESET_HIGH  (RESET_HIGH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .wr       (wr_sel),
      .wr_period(wr_period),
      .wr_high  (wr_high),
      .clk_out  (clk_out[i]),
      .tick     (tick[i]),
      .pending  (pending[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - self-checking bench for clk_div_bank
//
// Purpose: vector table, directed corner sequences and randomized traffic,
// all compared against a per-period waveform queue model.
// Ports: none (top-level bench).
module tb_clk_div_bank;

  localparam int NCH = 3;
  localparam int W   = 26;
  localparam int RP  = 9;
  localparam int RH  = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] en;
  logic           wr_en;
  logic [1:0]     wr_ch;
  logic [W-1:0]   wr_period, wr_high;
  logic [NCH-1:0] clk_out, tick, pending;

  int n_checks = 0;
  int n_fail   = 0;

  clk_div_bank #(
    .CHANNELS(NCH), .CH_W(2), .W(W), .RESET_PERIOD(RP), .RESET_HIGH(RH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_period(wr_period), .wr_high(wr_high),
    .clk_out(clk_out), .tick(tick), .pending(pending)
  );

  always #5 clk = ~clk;

  // Model: each started period is expanded into P+1 samples {tick, high};
  // one sample is consumed per edge, and an empty queue marks a boundary.
  int             m_p[NCH], m_h[NCH], s_p[NCH], s_h[NCH];
  bit             m_pend[NCH];
  logic [1:0]     mq[NCH][$];
  logic [NCH-1:0] e_clk, e_tick, e_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    bit         hit;
    logic [1:0] smp;
    for (int c = 0; c < NCH; c++) begin
      hit = wr_en && (int'(wr_ch) == c);
      smp = 2'b00;
      if (rst) begin
        m_p[c] = RP; m_h[c] = RH; m_pend[c] = 0;
        mq[c].delete();
      end else if (en[c] && mq[c].size() > 0) begin
        smp = mq[c].pop_front();
        if (hit) begin
          s_p[c] = int'(wr_period); s_h[c] = int'(wr_high); m_pend[c] = 1;
        end
      end else begin
        if (hit) begin
          m_p[c] = int'(wr_period); m_h[c] = int'(wr_high); m_pend[c] = 0;
        end else if (m_pend[c]) begin
          m_p[c] = s_p[c]; m_h[c] = s_h[c]; m_pend[c] = 0;
        end
        mq[c].delete();
        if (en[c]) begin
          for (int k = 0; k <= m_p[c]; k++) mq[c].push_back({k == 0, k < m_h[c]});
          smp = mq[c].pop_front();
        end
      end
      e_tick[c] = smp[1];
      e_clk[c]  = smp[0];
      e_pend[c] = m_pend[c];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model_clk_out", 32'(clk_out), 32'(e_clk));
    check("model_tick",    32'(tick),    32'(e_tick));
    check("model_pending", 32'(pending), 32'(e_pend));
  endtask

  task automatic set_wr(input bit we, input int ch, input int p, input int h);
    wr_en = we; wr_ch = 2'(ch); wr_period = W'(p); wr_high = W'(h);
  endtask

  // step until the model channel has exactly rem samples left in its period
  task automatic wait_rem(input int c, input int rem, input string name);
    int n = 0;
    while (mq[c].size() != rem && n < 60) begin step(); n++; end
    check(name, 32'(n < 60), 32'd1);
  endtask

  // cycles from one tick of channel c to the next
  task automatic measure(input int c, input int exp, input string name);
    int n = 0;
    while (!tick[c] && n < 200) begin step(); n++; end
    n = 0;
    do begin step(); n++; end while (!tick[c] && n < 200);
    check(name, 32'(n), 32'(exp));
  endtask

  typedef struct {
    logic           r;
    logic [NCH-1:0] e;
    logic           we;
    int             ch, p, h, reps;
    logic [NCH-1:0] xc, xt, xp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // reset with an ignored write, defaults P=9/H=5 on ch0
    tbl.push_back('{1'b1, 3'b111, 1'b1, 0, 2, 1, 3, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{1'b0, 3'b001, 1'b0, 0, 0, 0, 1, 3'b001, 3'b001, 3'b000});
    tbl.push_back('{1'b0, 3'b001, 1'b0, 0, 0, 0, 4, 3'b001, 3'b000, 3'b000});
    tbl.push_back('{1'b0, 3'b001, 1'b0, 0, 0, 0, 5, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{1'b0, 3'b001, 1'b0, 0, 0, 0, 1, 3'b001, 3'b001, 3'b000});
    // ch1 divide-by-1 (P=0, H=1)
    tbl.push_back('{1'b0, 3'b001, 1'b1, 1, 0, 1, 1, 3'b001, 3'b000, 3'b000});
    tbl.push_back('{1'b0, 3'b011, 1'b0, 0, 0, 0, 1, 3'b011, 3'b010, 3'b000});
    tbl.push_back('{1'b0, 3'b011, 1'b0, 0, 0, 0, 2, 3'b011, 3'b010, 3'b000});
    tbl.push_back('{1'b0, 3'b011, 1'b0, 0, 0, 0, 5, 3'b010, 3'b010, 3'b000});
    tbl.push_back('{1'b0, 3'b011, 1'b0, 0, 0, 0, 1, 3'b011, 3'b011, 3'b000});
    // ch1 P=3, H=0: low, tick every 4
    tbl.push_back('{1'b0, 3'b011, 1'b1, 1, 3, 0, 1, 3'b001, 3'b010, 3'b000});
    tbl.push_back('{1'b0, 3'b011, 1'b0, 0, 0, 0, 3, 3'b001, 3'b000, 3'b000});
    tbl.push_back('{1'b0, 3'b011, 1'b0, 0, 0, 0, 1, 3'b000, 3'b010, 3'b000});
    tbl.push_back('{1'b0, 3'b011, 1'b0, 0, 0, 0, 3, 3'b000, 3'b000, 3'b000});
    // ch1 P=3, H=7: constant high
    tbl.push_back('{1'b0, 3'b011, 1'b1, 1, 3, 7, 1, 3'b010, 3'b010, 3'b000});
    tbl.push_back('{1'b0, 3'b011, 1'b0, 0, 0, 0, 1, 3'b011, 3'b001, 3'b000});
    tbl.push_back('{1'b0, 3'b011, 1'b0, 0, 0, 0, 2, 3'b011, 3'b000, 3'b000});
    tbl.push_back('{1'b0, 3'b011, 1'b0, 0, 0, 0, 1, 3'b011, 3'b010, 3'b000});
    // ch0 glitch-free update written at cnt=4
    tbl.push_back('{1'b0, 3'b001, 1'b1, 0, 3, 2, 1, 3'b001, 3'b000, 3'b001});
    tbl.push_back('{1'b0, 3'b001, 1'b0, 0, 0, 0, 5, 3'b000, 3'b000, 3'b001});
    tbl.push_back('{1'b0, 3'b001, 1'b0, 0, 0, 0, 1, 3'b001, 3'b001, 3'b000});
    tbl.push_back('{1'b0, 3'b001, 1'b0, 0, 0, 0, 1, 3'b001, 3'b000, 3'b000});
    tbl.push_back('{1'b0, 3'b001, 1'b0, 0, 0, 0, 2, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{1'b0, 3'b001, 1'b0, 0, 0, 0, 1, 3'b001, 3'b001, 3'b000});

    rst = 1'b1; en = '0;
    set_wr(0, 0, 0, 0);
    for (int c = 0; c < NCH; c++) begin
      m_p[c] = RP; m_h[c] = RH; s_p[c] = 0; s_h[c] = 0; m_pend[c] = 0;
    end
    @(negedge clk);

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        rst = tbl[i].r; en = tbl[i].e;
        set_wr(tbl[i].we, tbl[i].ch, tbl[i].p, tbl[i].h);
        step();
        check($sformatf("tbl%0d_clk_out", i), 32'(clk_out), 32'(tbl[i].xc));
        check($sformatf("tbl%0d_tick", i),    32'(tick),    32'(tbl[i].xt));
        check($sformatf("tbl%0d_pending", i), 32'(pending), 32'(tbl[i].xp));
      end
    end

    // overwrite: two writes before the boundary, only the second applies
    set_wr(0, 0, 0, 0); en = 3'b100; step();
    set_wr(1, 2, 5, 1); step();
    set_wr(1, 2, 2, 2); step();
    set_wr(0, 0, 0, 0);
    check("overwrite_pending", 32'(pending[2]), 32'd1);
    measure(2, 3, "overwrite_period");

    // bypass: write exactly on the wrap edge
    wait_rem(2, 0, "bypass_sync");
    set_wr(1, 2, 4, 3); step();
    set_wr(0, 0, 0, 0);
    check("bypass_pending", 32'(pending[2]), 32'd0);
    check("bypass_tick", 32'(tick[2]), 32'd1);
    measure(2, 5, "bypass_period");

    // enable drop at cnt=6, restart, then reset at cnt=3
    en = 3'b000; set_wr(1, 0, 7, 3); step();
    set_wr(0, 0, 0, 0); en = 3'b001; step();
    wait_rem(0, 1, "dis_sync");
    en = 3'b000; step();
    check("dis_clk_out", 32'(clk_out[0]), 32'd0);
    check("dis_tick", 32'(tick[0]), 32'd0);
    en = 3'b001; step();
    check("restart_tick", 32'(tick[0]), 32'd1);
    check("restart_clk_out", 32'(clk_out[0]), 32'd1);
    wait_rem(0, 4, "rst_sync");
    rst = 1'b1; step();
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    rst = 1'b0;
    measure(0, RP + 1, "rst_default_period");

    // invalid channel address
    en = 3'b111;
    for (int i = 0; i < 4; i++) begin set_wr(1, 3, 1, 1); step(); end
    set_wr(0, 0, 0, 0);
    check("invalid_pending", 32'(pending), 32'd0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) en = 3'($urandom_range(0, 7));
      set_wr($urandom_range(0, 5) == 0, $urandom_range(0, 3),
             $urandom_range(0, 12), $urandom_range(0, 15));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
